data_ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: instruction fetch (read-only) and execute (read/write).

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_select.sv | 31 +++
 rtl/data_ram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the data RAM arbiter: FSM states, grant encoding and
// default read timeout.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_EXEC  = 1'b1
    } grant_t;

    localparam int DEFAULT_TIMEOUT = 4;

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner pick between fetch and execute requests.
// RAM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last.
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic   fReq,
    input  logic   eReq,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  grant_t lastGnt,
`endif
    output logic   anyReq,
    output grant_t winner
);

    always_comb begin
        anyReq = fReq | eReq;
        winner = GNT_FETCH;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (fReq && eReq) begin
            winner = (lastGnt == GNT_EXEC) ? GNT_FETCH : GNT_EXEC;
        end else if (eReq) begin
            winner = GNT_EXEC;
        end
`else
        if (eReq) begin
            winner = GNT_EXEC;
        end
`endif
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Serialises fetch/execute accesses onto the single-port data RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module data_ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int width   = 8,
    parameter int length  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [length-1:0] f_addr,
    output logic              f_ack,
    output logic [width-1:0]  f_data,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [length-1:0] e_addr,
    input  logic [width-1:0]  e_wdata,
    output logic              e_ack,
    output logic [width-1:0]  e_rdata,
    output logic              rd_err,
    output logic              busy,
    output logic              ram_we,
    output logic              ram_re,
    output logic [length-1:0] ram_addr,
    output logic [length-1:0] ram_read_addr,
    output logic [width-1:0]  ram_wdata,
    input  logic              ram_data_ready,
    input  logic [width-1:0]  ram_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, stateNext;
    grant_t            curGnt, curGntNext;
    grant_t            winner;
    logic              anyReq;
    logic              curWe, curWeNext;
    logic [length-1:0] addrReg, addrNext;
    logic [width-1:0]  wdataReg, wdataNext;
    logic [width-1:0]  fDataReg, fDataNext;
    logic [width-1:0]  eDataReg, eDataNext;
    logic              fAckReg, fAckNext;
    logic              eAckReg, eAckNext;
    logic              errReg, errNext;
    logic              weReg, weNext;
    logic              reReg, reNext;
    logic [CW-1:0]     cnt, cntNext;
    logic              doneRd, doneErr;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    grant_t gntPtr, gntPtrNext;

    always_comb begin
        gntPtrNext = gntPtr;
        if (state == IDLE && anyReq) begin
            gntPtrNext = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            gntPtr <= GNT_FETCH;
        end else begin
            gntPtr <= gntPtrNext;
        end
    end
`endif

    ram_arb_select uSelect (
        .fReq    (f_req),
        .eReq    (e_req),
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .lastGnt (gntPtr),
`endif
        .anyReq  (anyReq),
        .winner  (winner)
    );

    always_comb begin
        stateNext  = state;
        curGntNext = curGnt;
        curWeNext  = curWe;
        addrNext   = addrReg;
        wdataNext  = wdataReg;
        fDataNext  = fDataReg;
        eDataNext  = eDataReg;
        cntNext    = cnt;
        fAckNext   = 1'b0;
        eAckNext   = 1'b0;
        errNext    = 1'b0;
        weNext     = 1'b0;
        reNext     = 1'b0;
        doneRd     = 1'b0;
        doneErr    = 1'b0;

        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    curGntNext = winner;
                    stateNext  = ISSUE;
                    if (winner == GNT_EXEC) begin
                        curWeNext = e_we;
                        addrNext  = e_addr;
                        wdataNext = e_wdata;
                    end else begin
                        curWeNext = 1'b0;
                        addrNext  = f_addr;
                    end
                    // Strobes load here so they span the whole ISSUE cycle.
                    weNext = curWeNext;
                    reNext = ~curWeNext;
                end
            end
            ISSUE: begin
                if (curWe) begin
                    eAckNext  = 1'b1;
                    stateNext = IDLE;
                end else if (ram_data_ready) begin
                    doneRd = 1'b1;
                end else begin
                    reNext    = 1'b1;
                    cntNext   = CW'(1);
                    stateNext = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (ram_data_ready) begin
                    doneRd = 1'b1;
                end else if (cnt == CW'(TIMEOUT)) begin
                    doneErr = 1'b1;
                end else begin
                    reNext  = 1'b1;
                    cntNext = cnt + CW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // A timed-out read acks but leaves the data register untouched.
        if (doneRd || doneErr) begin
            stateNext = IDLE;
            errNext   = doneErr;
            if (curGnt == GNT_EXEC) begin
                eAckNext = 1'b1;
                if (doneRd) begin
                    eDataNext = ram_rdata;
                end
            end else begin
                fAckNext = 1'b1;
                if (doneRd) begin
                    fDataNext = ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            curGnt   <= GNT_FETCH;
            curWe    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            fDataReg <= '0;
            eDataReg <= '0;
            cnt      <= '0;
            fAckReg  <= 1'b0;
            eAckReg  <= 1'b0;
            errReg   <= 1'b0;
            weReg    <= 1'b0;
            reReg    <= 1'b0;
        end else begin
            state    <= stateNext;
            curGnt   <= curGntNext;
            curWe    <= curWeNext;
            addrReg  <= addrNext;
            wdataReg <= wdataNext;
            fDataReg <= fDataNext;
            eDataReg <= eDataNext;
            cnt      <= cntNext;
            fAckReg  <= fAckNext;
            eAckReg  <= eAckNext;
            errReg   <= errNext;
            weReg    <= weNext;
            reReg    <= reNext;
        end
    end

    assign f_ack         = fAckReg;
    assign f_data        = fDataReg;
    assign e_ack         = eAckReg;
    assign e_rdata       = eDataReg;
    assign rd_err        = errReg;
    assign busy          = (state != IDLE);
    assign ram_we        = weReg;
    assign ram_re        = reReg;
    assign ram_addr      = addrReg;
    assign ram_read_addr = addrReg;
    assign ram_wdata     = wdataReg;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter with a behavioural negedge RAM.
// Expected acks are queued by the driver and popped by a negedge monitor.
module tb_data_ram_arbiter;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       f_req = 1'b0;
    logic [7:0] f_addr = '0;
    logic       f_ack;
    logic [7:0] f_data;
    logic       e_req = 1'b0;
    logic       e_we = 1'b0;
    logic [7:0] e_addr = '0;
    logic [7:0] e_wdata = '0;
    logic       e_ack;
    logic [7:0] e_rdata;
    logic       rd_err;
    logic       busy;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_addr;
    logic [7:0] ram_read_addr;
    logic [7:0] ram_wdata;
    logic       ram_data_ready = 1'b0;
    logic [7:0] ram_rdata = '0;

    data_ram_arbiter dut (
        .clk            (clk),
        .clr            (clr),
        .f_req          (f_req),
        .f_addr         (f_addr),
        .f_ack          (f_ack),
        .f_data         (f_data),
        .e_req          (e_req),
        .e_we           (e_we),
        .e_addr         (e_addr),
        .e_wdata        (e_wdata),
        .e_ack          (e_ack),
        .e_rdata        (e_rdata),
        .rd_err         (rd_err),
        .busy           (busy),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_addr       (ram_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_wdata      (ram_wdata),
        .ram_data_ready (ram_data_ready),
        .ram_rdata      (ram_rdata)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFail = 0;

    typedef struct {
        bit         isExec;
        logic [7:0] data;
        bit         err;
        int         cyc;
        string      name;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // RAM model: commands sampled at negedge, ready after 'stall' extra cycles.
    logic [7:0] mem [256];
    int reCnt = 0;
    int stall = 0;
    bit tieLow = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    end

    always @(negedge clk) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
        if (ram_re) begin
            reCnt = reCnt + 1;
            ram_rdata = mem[ram_read_addr];
            ram_data_ready = !tieLow && (reCnt > stall);
        end else begin
            reCnt = 0;
            ram_data_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (f_ack || e_ack) begin
            if (expQ.size() == 0) begin
                chk("unexpected_ack", {30'd0, f_ack, e_ack}, 0);
            end else begin
                cur = expQ.pop_front();
                chk({cur.name, "_port"}, {30'd0, f_ack, e_ack},
                    cur.isExec ? 32'd1 : 32'd2);
                chk({cur.name, "_data"},
                    cur.isExec ? e_rdata : f_data, cur.data);
                chk({cur.name, "_err"}, rd_err, cur.err);
                chk({cur.name, "_cyc"}, cyc, cur.cyc);
            end
        end else if (rd_err) begin
            chk("err_without_ack", rd_err, 0);
        end
        if (ram_we || ram_re) chk("we_re_excl", ram_we & ram_re, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(bit ex, logic [7:0] d, bit er, int c, string nm);
        exp_t t;
        t.isExec = ex;
        t.data   = d;
        t.err    = er;
        t.cyc    = c;
        t.name   = nm;
        expQ.push_back(t);
    endtask

    task automatic waitAck(bit ex, string nm);
        int n = 0;
        while (!(ex ? e_ack : f_ack) && n < 16) begin
            tick();
            n++;
        end
        if (!(ex ? e_ack : f_ack)) chk({nm, "_ack_seen"}, 0, 1);
    endtask

    task automatic doReset();
        clr = 1'b1;
        f_req = 1'b1;
        e_req = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_acks", {f_ack, e_ack, rd_err}, 0);
        chk("rst_strobes", {ram_we, ram_re}, 0);
        chk("rst_addr", {ram_addr, ram_read_addr, ram_wdata}, 0);
        chk("rst_data", {f_data, e_rdata}, 0);
        f_req = 1'b0;
        e_req = 1'b0;
        clr = 1'b0;
        tick();
    endtask

    task automatic doTxn(bit ex, bit we, logic [7:0] a, logic [7:0] wd,
                         int st, bit tl, logic [7:0] expD, bit expE,
                         int lat, string nm);
        int n;
        int c;
        stall = st;
        tieLow = tl;
        if (ex) begin
            e_req = 1'b1;
            e_we = we;
            e_addr = a;
            e_wdata = wd;
        end else begin
            f_req = 1'b1;
            f_addr = a;
        end
        c = cyc;
        push(ex, expD, expE, c + lat, nm);
        tick();
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_we"}, ram_we, we);
        chk({nm, "_re"}, ram_re, !we);
        chk({nm, "_addr"}, {ram_addr, ram_read_addr}, {a, a});
        if (we) chk({nm, "_wdata"}, ram_wdata, wd);
        n = 0;
        while (!(ex ? e_ack : f_ack) && n < 16) begin
            if (!we && busy) chk({nm, "_re_held"}, ram_re, 1);
            tick();
            n++;
        end
        if (!(ex ? e_ack : f_ack)) chk({nm, "_ack_seen"}, 0, 1);
        chk({nm, "_idle_strobes"}, {ram_we, ram_re}, 0);
        chk({nm, "_busy_done"}, busy, 0);
        e_req = 1'b0;
        f_req = 1'b0;
        tick();
        tieLow = 1'b0;
        stall = 0;
    endtask

    initial begin
        int c;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        doReset();

        // Write then read back through the fetch port.
        doTxn(1, 1, 8'h05, 8'h3C, 0, 0, 8'h00, 0, 2, "t1_wr");
        doTxn(0, 0, 8'h05, 8'h00, 0, 0, 8'h3C, 0, 2, "t1_rd");

        // Simultaneous requests; each drops after its own ack.
        doReset();
        f_req = 1'b1;
        f_addr = 8'h01;
        e_req = 1'b1;
        e_we = 1'b0;
        e_addr = 8'h02;
        c = cyc;
        push(1, 8'hA7, 0, c + 2, "t2a_ex");
        push(0, 8'hA4, 0, c + 4, "t2a_f");
        waitAck(1, "t2a_ex");
        e_req = 1'b0;
        waitAck(0, "t2a_f");
        f_req = 1'b0;
        tick();

        // Both held across two ties.
        f_req = 1'b1;
        e_req = 1'b1;
        c = cyc;
        push(1, 8'hA7, 0, c + 2, "t2b_first");
`ifdef RAM_ARB_ROUND_ROBIN_EN
        push(0, 8'hA4, 0, c + 4, "t2b_second");
`else
        push(1, 8'hA7, 0, c + 4, "t2b_second");
`endif
        for (int i = 0; i < 4; i++) tick();
        f_req = 1'b0;
        e_req = 1'b0;
        tick();

        // Stalled read and timed-out read.
        doTxn(1, 0, 8'h05, 8'h00, 2, 0, 8'h3C, 0, 4, "t3_stall");
        doTxn(0, 0, 8'h03, 8'h00, 0, 1, 8'hA4, 1, 6, "t4_tmo");

        // Reset in the middle of WAIT_RD.
        tieLow = 1'b1;
        f_req = 1'b1;
        f_addr = 8'h07;
        tick();
        tick();
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_re", ram_re, 1);
        clr = 1'b1;
        tick();
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_re", ram_re, 0);
        chk("t5_rst_ack", {f_ack, rd_err}, 0);
        chk("t5_rst_data", f_data, 0);
        clr = 1'b0;
        f_req = 1'b0;
        tieLow = 1'b0;
        tick();
        doTxn(0, 0, 8'h05, 8'h00, 0, 0, 8'h3C, 0, 2, "t5_after");

        // e_req held across three writes.
        e_req = 1'b1;
        e_we = 1'b1;
        e_addr = 8'h10;
        e_wdata = 8'h11;
        c = cyc;
        push(1, 8'h00, 0, c + 2, "t6_w10");
        tick();
        tick();
        e_addr = 8'h11;
        e_wdata = 8'h22;
        push(1, 8'h00, 0, c + 4, "t6_w11");
        tick();
        tick();
        e_addr = 8'h12;
        e_wdata = 8'h33;
        push(1, 8'h00, 0, c + 6, "t6_w12");
        tick();
        tick();
        e_req = 1'b0;
        e_we = 1'b0;
        tick();
        doTxn(0, 0, 8'h10, 8'h00, 0, 0, 8'h11, 0, 2, "t6_r10");
        doTxn(0, 0, 8'h11, 8'h00, 0, 0, 8'h22, 0, 2, "t6_r11");
        doTxn(0, 0, 8'h12, 8'h00, 0, 0, 8'h33, 0, 2, "t6_r12");

        tick();
        chk("pending_acks", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
